// File: rtl/rv_decode_pkg.sv
// Shared definitions for the RV64 decode stage: opcodes, instruction
// formats and the layout of the ID/EX pipeline register.
package rv_decode_pkg;

  localparam int XLEN      = 64;
  localparam int REG_PTR_W = 5;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X
  } fmt_e;

  // Everything the execute stage needs from one decoded instruction.
  typedef struct packed {
    logic [XLEN-1:0]      rs1_val;
    logic [XLEN-1:0]      rs2_val;
    logic [XLEN-1:0]      imm;
    logic [REG_PTR_W-1:0] rd;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 we;
    logic                 illegal;
  } id_ex_t;

  // Map an opcode onto its encoding format; unknown opcodes become FMT_X.
  function automatic fmt_e decode_fmt(input logic [6:0] opcode);
    fmt_e f;
    case (opcode)
      OPC_OP, OPC_OP_32:                             f = FMT_R;
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: f = FMT_I;
      OPC_STORE:                                     f = FMT_S;
      OPC_BRANCH:                                    f = FMT_B;
      OPC_LUI, OPC_AUIPC:                            f = FMT_U;
      OPC_JAL:                                       f = FMT_J;
      default:                                       f = FMT_X;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/generador_inmediato.sv
// Combinational immediate extraction: rebuilds the RV immediate for the
// given format and sign-extends it from inst[31] to the operand width.
module generador_inmediato
  import rv_decode_pkg::*;
#(
  parameter int ILEN = 32,
  parameter int Bits = 64
) (
  input  logic [ILEN-1:0] inst,
  input  fmt_e            fmt,
  output logic [Bits-1:0] imm
);

  // The opcode bits are already folded into fmt by the caller.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^inst[6:0];

  // R-type and unrecognised instructions carry no immediate.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{(Bits-12){inst[31]}}, inst[31:20]};
      FMT_S: imm = {{(Bits-12){inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm = {{(Bits-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                    inst[11:8], 1'b0};
      FMT_U: imm = {{(Bits-32){inst[31]}}, inst[31:12], 12'b0};
      FMT_J: imm = {{(Bits-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                    inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/etapa_decodificacion.sv
// RV64 instruction-decode stage. Reads operands from BancoRegistros,
// bypasses a same-cycle writeback, tracks outstanding writers in a
// scoreboard to stall on RAW/WAW hazards, and registers the decoded
// instruction into the ID/EX register.
module etapa_decodificacion
  import rv_decode_pkg::*;
#(
  parameter  int N     = 32,
  parameter  int Bits  = 64,
  parameter  int ILEN  = 32,
  localparam int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [ILEN-1:0]  inst,
  output logic             inst_ready,
  input  logic             flush,
  output logic [PTR_W-1:0] ptr_rd_1,
  output logic [PTR_W-1:0] ptr_rd_2,
  input  logic [Bits-1:0]  data_rd_1,
  input  logic [Bits-1:0]  data_rd_2,
  input  logic             wb_en,
  input  logic [PTR_W-1:0] wb_ptr,
  input  logic [Bits-1:0]  wb_data,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [Bits-1:0]  ex_rs1_val,
  output logic [Bits-1:0]  ex_rs2_val,
  output logic [Bits-1:0]  ex_imm,
  output logic [PTR_W-1:0] ex_rd,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic             ex_we,
  output logic             ex_illegal
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [PTR_W-1:0] rd;
  logic [PTR_W-1:0] rs1;
  logic [PTR_W-1:0] rs2;
  fmt_e             fmt;
  logic [Bits-1:0]  imm;

  logic             uses_rs1;
  logic             uses_rs2;
  logic             writes_fmt;
  logic             writes_rd;
  logic             wb_hit_rs1;
  logic             wb_hit_rs2;
  logic             wb_hit_rd;
  logic             stall;
  logic             accept;
  logic [Bits-1:0]  rs1_val;
  logic [Bits-1:0]  rs2_val;

  logic             ex_valid_q;
  logic             ex_valid_d;
  id_ex_t           id_ex_q;
  id_ex_t           id_ex_d;
  logic [N-1:0]     pending_q;
  logic [N-1:0]     pending_d;

  assign opcode   = inst[6:0];
  assign rd       = inst[7 +: PTR_W];
  assign funct3   = inst[14:12];
  assign rs1      = inst[15 +: PTR_W];
  assign rs2      = inst[20 +: PTR_W];
  assign funct7   = inst[31:25];
  assign fmt      = decode_fmt(opcode);

  assign ptr_rd_1 = rs1;
  assign ptr_rd_2 = rs2;

  generador_inmediato #(
    .ILEN (ILEN),
    .Bits (Bits)
  ) u_generador_inmediato (
    .inst (inst),
    .fmt  (fmt),
    .imm  (imm)
  );

  // Which register ports the instruction format actually uses.
  always_comb begin
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    writes_fmt = 1'b0;
    case (fmt)
      FMT_R: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        writes_fmt = 1'b1;
      end
      FMT_I: begin
        uses_rs1   = 1'b1;
        writes_fmt = 1'b1;
      end
      FMT_S, FMT_B: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      FMT_U, FMT_J: writes_fmt = 1'b1;
      default: begin
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        writes_fmt = 1'b0;
      end
    endcase
    writes_rd = writes_fmt && (rd != '0);
  end

  // Hazard detection: a pending register retiring this very cycle no
  // longer blocks, since its value arrives through the bypass.
  always_comb begin
    wb_hit_rs1 = wb_en && (wb_ptr == rs1);
    wb_hit_rs2 = wb_en && (wb_ptr == rs2);
    wb_hit_rd  = wb_en && (wb_ptr == rd);
    stall = inst_valid &&
            ((uses_rs1 && (rs1 != '0) && pending_q[rs1] && !wb_hit_rs1) ||
             (uses_rs2 && (rs2 != '0) && pending_q[rs2] && !wb_hit_rs2) ||
             (writes_rd && pending_q[rd] && !wb_hit_rd));
    inst_ready = !stall && !flush && (!ex_valid_q || ex_ready);
    accept     = inst_valid && inst_ready;
  end

  // Operand selection: x0 reads zero, a same-cycle writeback wins over
  // the stale register file value.
  always_comb begin
    if (rs1 == '0) begin
      rs1_val = '0;
    end else if (wb_hit_rs1) begin
      rs1_val = wb_data;
    end else begin
      rs1_val = data_rd_1;
    end
    if (rs2 == '0) begin
      rs2_val = '0;
    end else if (wb_hit_rs2) begin
      rs2_val = wb_data;
    end else begin
      rs2_val = data_rd_2;
    end
  end

  // Next state of the ID/EX register and the pending-write scoreboard.
  always_comb begin
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end

    id_ex_d = id_ex_q;
    if (accept) begin
      id_ex_d.rs1_val = rs1_val;
      id_ex_d.rs2_val = rs2_val;
      id_ex_d.imm     = imm;
      id_ex_d.rd      = rd;
      id_ex_d.opcode  = opcode;
      id_ex_d.funct3  = funct3;
      id_ex_d.funct7  = funct7;
      id_ex_d.we      = writes_rd;
      id_ex_d.illegal = (fmt == FMT_X);
    end

    pending_d = pending_q;
    if (wb_en) begin
      pending_d[wb_ptr] = 1'b0;
    end
    if (flush && ex_valid_q && id_ex_q.we) begin
      pending_d[id_ex_q.rd] = 1'b0;
    end
    if (accept && writes_rd) begin
      pending_d[rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; reset empties the pipeline and forgets all writers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      id_ex_q    <= '0;
      pending_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      id_ex_q    <= id_ex_d;
      pending_q  <= pending_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs1_val = id_ex_q.rs1_val;
  assign ex_rs2_val = id_ex_q.rs2_val;
  assign ex_imm     = id_ex_q.imm;
  assign ex_rd      = id_ex_q.rd;
  assign ex_opcode  = id_ex_q.opcode;
  assign ex_funct3  = id_ex_q.funct3;
  assign ex_funct7  = id_ex_q.funct7;
  assign ex_we      = id_ex_q.we;
  assign ex_illegal = id_ex_q.illegal;

endmodule

// File: doc/etapa_decodificacion.md
Name: etapa_decodificacion

Overview:
- RV64 instruction-decode stage sitting directly upstream of BancoRegistros.
- Takes a fetched 32-bit instruction under a valid/ready handshake and drives the register file read pointers from it.
- Captures both read operands, the decoded fields and the sign-extended immediate into a registered ID/EX output.
- Keeps a pending-write scoreboard so it stalls on RAW/WAW hazards until writeback retires the producer.

Parameters:
- N, 32, number of architectural registers; pointer width is $clog2(N).
- Bits, 64, register and operand width.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_valid  in  1  upstream instruction valid.
- inst  in  ILEN  instruction word.
- inst_ready  out  1  stage accepts inst this cycle.
- flush  in  1  kill the instruction held in the ID/EX register.
- ptr_rd_1  out  $clog2(N)  rs1 pointer to BancoRegistros; combinational from inst[19:15].
- ptr_rd_2  out  $clog2(N)  rs2 pointer to BancoRegistros; combinational from inst[24:20].
- data_rd_1  in  Bits  BancoRegistros read data 1.
- data_rd_2  in  Bits  BancoRegistros read data 2.
- wb_en  in  1  writeback strobe; same signal that drives BancoRegistros wr_en.
- wb_ptr  in  $clog2(N)  writeback destination; same as ptr_wr.
- wb_data  in  Bits  writeback data; same as data_wr.
- ex_ready  in  1  downstream accepts ID/EX contents.
- ex_valid  out  1  ID/EX register holds a live instruction.
- ex_rs1_val  out  Bits  operand 1.
- ex_rs2_val  out  Bits  operand 2.
- ex_imm  out  Bits  sign-extended immediate.
- ex_rd  out  $clog2(N)  destination register.
- ex_opcode  out  7  opcode field.
- ex_funct3  out  3  funct3 field.
- ex_funct7  out  7  funct7 field.
- ex_we  out  1  instruction writes rd (and rd != 0).
- ex_illegal  out  1  unrecognised opcode.

Behaviour:
- Reset (async, rst=1):
  - ex_valid = 0, every ex_* output = 0, scoreboard pending[N-1:0] = 0.
  - inst_ready follows its combinational equation with pending = 0 and ex_valid = 0.
- Opcode classes:
  - R: OP 0110011, OP-32 0111011.
  - I: OP-IMM 0010011, OP-IMM-32 0011011, LOAD 0000011, JALR 1100111.
  - S: STORE 0100011.
  - B: BRANCH 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: JAL 1101111.
  - Anything else sets ex_illegal = 1 with ex_we = 0 and ex_imm = 0.
- Register usage:
  - uses_rs1: R, I, S, B.
  - uses_rs2: R, S, B.
  - writes_rd: R, I, U, J, and only when rd != 0.
- Immediates: standard RV I/S/B/U/J encodings, sign-extended from inst[31] to Bits.
  - U: inst[31:12] << 12, sign-extended.
  - R-type: ex_imm = 0.
- Operand selection (per operand):
  - rs == 0 -> 0.
  - else if wb_en && wb_ptr == rs -> wb_data (bypass; the register file write lands on the same edge).
  - else -> data_rd_x.
- Hazard stall: stall = inst_valid && any of the following, where "live" means pending and not cleared this cycle (not (wb_en && wb_ptr == reg)):
  - uses_rs1 && rs1 != 0 && pending[rs1] live.
  - uses_rs2 && rs2 != 0 && pending[rs2] live.
  - writes_rd && pending[rd] live (WAW).
- Handshake:
  - inst_ready = !stall && !flush && (!ex_valid || ex_ready).
  - accept = inst_valid && inst_ready.
  - Latency: 1 cycle from accept to ex_valid.
  - ex_* fields change only on accept.
- ex_valid next, in priority order:
  - flush -> 0.
  - accept -> 1.
  - ex_ready -> 0.
  - otherwise hold.
- Scoreboard, each cycle:
  - Clear pending[wb_ptr] when wb_en.
  - Clear pending[ex_rd] when flush && ex_valid && ex_we.
  - Set pending[rd] on accept && writes_rd.
  - Set beats clear on the same index in the same cycle.
  - pending[0] is never set.
- Reset mid-operation: all pending bits are lost; the pipeline is reset together, so no retirement is expected afterwards.

Decomposition:
- Package rv_decode_pkg holds:
  - Opcode localparams.
  - typedef enum for instruction format {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X}.
  - typedef struct packed for the ID/EX bundle.
- One sub-module, generador_inmediato: combinational inst + format -> Bits immediate.
- The top holds the scoreboard, operand bypass and ID/EX register.

Test Plan:
- Reset mid-stream: rst pulse while ex_valid = 1 -> ex_valid = 0, pending = 0, and inst_ready = 1 as soon as rst deasserts with inst_valid = 1.
- Operand capture: preload x5 = 0x11, x6 = 0x22 via wb_en, then ADD x7,x5,x6 (0x006283B3) -> next cycle ex_valid = 1, ex_rs1_val = 0x11, ex_rs2_val = 0x22, ex_rd = 7, ex_we = 1; pending[7] = 1.
- RAW stall: then ADDI x8,x7,-1 (0xFFF38413) -> inst_ready = 0 until wb_en with wb_ptr = 7, wb_data = 0x33; accepted that same cycle with ex_rs1_val = 0x33 (bypass) and ex_imm = 0xFFFF_FFFF_FFFF_FFFF.
- Immediates and illegal: SW, BEQ with offset -4, LUI 0x80000, JAL -> correct sign-extended ex_imm for each (LUI -> 0xFFFF_FFFF_8000_0000), ex_we = 0 for S/B; opcode 0x7F -> ex_illegal = 1, no pending bit set.
- Back-pressure and flush: ex_ready = 0 with ex_valid = 1 -> inst_ready = 0 and ex_* stable; then assert flush -> ex_valid = 0 next cycle and pending[ex_rd] cleared.
- x0 handling: ADDI x0,x0,5 -> ex_we = 0, pending unchanged, ex_rs1_val = 0 even if wb_en with wb_ptr = 0.
